// File: rtl/line_memory_responder.sv
// line_memory_responder
//   Memory-side responder for a 128-bit line interface. Accepts one line
//   request at a time, waits LATENCY cycles, then either writes the line into
//   a backing array or returns the stored line. Completion is signalled with
//   a single-cycle mem_ready_o pulse, followed by one cool-down cycle in which
//   requests are ignored.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   mem_read_i   line read request (level, held until ready)
//   mem_write_i  line write request (level, held until ready)
//   mem_addr_i   28-bit line address, only [IDX_W-1:0] used (upper bits alias)
//   mem_wdata_i  128-bit write line data
//   mem_rdata_o  128-bit registered read data, held until the next read completes
//   mem_ready_o  one-cycle completion pulse
//   busy_o       high whenever the responder is not idle
//   proto_err_o  one-cycle pulse after accepting a read+write request
module line_memory_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned IDX_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read_i,
  input  logic         mem_write_i,
  input  logic [27:0]  mem_addr_i,
  input  logic [127:0] mem_wdata_i,
  output logic [127:0] mem_rdata_o,
  output logic         mem_ready_o,
  output logic         busy_o,
  output logic         proto_err_o
);

  localparam int unsigned Lines  = 1 << IDX_W;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StReady,
    StCool
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [7:0]       r_cnt;
  logic             r_op_wr;
  logic [IDX_W-1:0] r_idx;
  logic [127:0]     r_wdata;
  logic [127:0]     r_rdata;
  logic             r_proto_err;
  logic [127:0]     r_mem [Lines];

  logic             w_req;
  logic             w_accept;
  logic             w_enter_ready;
  logic             w_rd_op;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_load_rd;
  logic             w_unused_addr;

  // Upper address bits are deliberately ignored (aliasing).
  assign w_unused_addr = ^mem_addr_i[27:IDX_W];

  assign w_req    = mem_read_i | mem_write_i;
  assign w_accept = (r_state == StIdle) & w_req;

  // With LATENCY==1 the READY state is entered straight from IDLE, before the
  // op/index registers are loaded, so the read source comes from the inputs.
  assign w_enter_ready = (w_state_next == StReady) & (r_state != StReady);
  assign w_rd_op       = (r_state == StIdle) ? ~mem_write_i : ~r_op_wr;
  assign w_rd_idx      = (r_state == StIdle) ? mem_addr_i[IDX_W-1:0] : r_idx;
  assign w_load_rd     = w_enter_ready & w_rd_op;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_state_next = (LATENCY == 1) ? StReady : StWait;
        end
      end
      StWait: begin
        if (r_cnt == 8'd1) begin
          w_state_next = StReady;
        end
      end
      StReady: w_state_next = StCool;
      StCool:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mem_ready_o = 1'b0;
    busy_o      = 1'b1;
    unique case (r_state)
      StIdle:  busy_o      = 1'b0;
      StReady: mem_ready_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_rdata_o = r_rdata;
  assign proto_err_o = r_proto_err;

  // Request latch, latency counter and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 8'd0;
      r_op_wr     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      // Read+write together is executed as a write and flagged.
      r_proto_err <= w_accept & mem_read_i & mem_write_i;
      if (w_accept) begin
        r_op_wr <= mem_write_i;
        r_idx   <= mem_addr_i[IDX_W-1:0];
        r_wdata <= mem_wdata_i;
        r_cnt   <= LAT_M1;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_load_rd) begin
        r_rdata <= r_mem[w_rd_idx];
      end
    end
  end

  // Backing array: not cleared by reset; a reset during READY drops the write.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == StReady) && r_op_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_line_memory_responder.sv
module tb_line_memory_responder;

  localparam logic [127:0] DEAD = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
  localparam logic [127:0] P6   = 128'h66666666_66666666_66666666_66666666;
  localparam logic [127:0] P9   = 128'h99999999_99999999_99999999_99999999;
  localparam logic [127:0] P21  = 128'h21212121_21212121_21212121_21212121;
  localparam logic [127:0] B2B  = 128'hB2B0B2B0_11112222_33334444_B2B0B2B0;
  localparam logic [127:0] D1   = 128'hD1D1D1D1_00000000_00000000_D1D1D1D1;
  localparam logic [127:0] D2   = 128'hD2D2D2D2_FFFFFFFF_FFFFFFFF_D2D2D2D2;
  localparam logic [127:0] E1   = 128'hE1E1E1E1_12345678_9ABCDEF0_E1E1E1E1;
  localparam logic [127:0] NEWD = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
  localparam logic [127:0] L1   = 128'h1A1A1A1A_2B2B2B2B_3C3C3C3C_4D4D4D4D;

  logic clk;
  logic rst;

  logic         a_rd, a_wr, a_ready, a_busy, a_perr;
  logic [27:0]  a_addr;
  logic [127:0] a_wdata, a_rdata;

  logic         b_rd, b_wr, b_ready, b_busy, b_perr;
  logic [27:0]  b_addr;
  logic [127:0] b_wdata, b_rdata;

  int total;
  int bad;

  line_memory_responder #(.LATENCY(4), .IDX_W(8)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .mem_read_i (a_rd),
    .mem_write_i(a_wr),
    .mem_addr_i (a_addr),
    .mem_wdata_i(a_wdata),
    .mem_rdata_o(a_rdata),
    .mem_ready_o(a_ready),
    .busy_o     (a_busy),
    .proto_err_o(a_perr)
  );

  line_memory_responder #(.LATENCY(1), .IDX_W(8)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .mem_read_i (b_rd),
    .mem_write_i(b_wr),
    .mem_addr_i (b_addr),
    .mem_wdata_i(b_wdata),
    .mem_rdata_o(b_rdata),
    .mem_ready_o(b_ready),
    .busy_o     (b_busy),
    .proto_err_o(b_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on the LATENCY=4 instance, hold it until ready, then
  // step through the cool-down cycle. lat = cycles from request to ready.
  task automatic op_a(input logic wr, input logic rd, input logic [27:0] addr,
                      input logic [127:0] data, output int lat);
    @(posedge clk); #1;
    a_wr = wr; a_rd = rd; a_addr = addr; a_wdata = data;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!a_ready && lat < 20);
    a_wr = 1'b0; a_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b want=0", a_ready); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_a_busy got=%b want=0", a_busy); end
    total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL reset_a_perr got=%b want=0", a_perr); end
    total++; if (a_rdata !== 128'h0) begin bad++; $display("FAIL reset_a_rdata got=%h want=0", a_rdata); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready got=%b want=0", b_ready); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL reset_b_busy got=%b want=0", b_busy); end
    total++; if (b_rdata !== 128'h0) begin bad++; $display("FAIL reset_b_rdata got=%h want=0", b_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    int lat;
    op_a(1'b1, 1'b0, 28'h0000006, P6, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL preload6_lat got=%0d want=4", lat); end
    op_a(1'b1, 1'b0, 28'h0000009, P9, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL preload9_lat got=%0d want=4", lat); end
    op_a(1'b1, 1'b0, 28'h0000021, P21, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL preload21_lat got=%0d want=4", lat); end
  endtask

  task automatic test_write_timing();
    @(posedge clk); #1;
    a_wr = 1'b1; a_addr = 28'h0000005; a_wdata = DEAD;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL wr_busy_c0 got=%b want=0", a_busy); end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      total++;
      if (a_ready !== (k == 4)) begin
        bad++; $display("FAIL wr_ready_c%0d got=%b want=%b", k, a_ready, (k == 4));
      end
      total++;
      if (a_busy !== (k <= 5)) begin
        bad++; $display("FAIL wr_busy_c%0d got=%b want=%b", k, a_busy, (k <= 5));
      end
      if (k == 4) a_wr = 1'b0;
    end
  endtask

  task automatic test_read();
    int lat;
    op_a(1'b0, 1'b1, 28'h0000005, '0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd5_lat got=%0d want=4", lat); end
    total++; if (a_rdata !== DEAD) begin bad++; $display("FAIL rd5_data got=%h want=%h", a_rdata, DEAD); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (a_rdata !== DEAD) begin bad++; $display("FAIL rd5_hold got=%h want=%h", a_rdata, DEAD); end
    op_a(1'b0, 1'b1, 28'h0000006, '0, lat);
    total++; if (a_rdata !== P6) begin bad++; $display("FAIL rd6_data got=%h want=%h", a_rdata, P6); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge clk); #1;
    a_wr = 1'b1; a_addr = 28'h1000005; a_wdata = B2B;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!a_ready && n < 20);
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_wr_lat got=%0d want=4", n); end
    // Cool-down cycle: switch straight to a read of the aliased line.
    @(posedge clk); #1; n++;
    a_wr = 1'b0; a_rd = 1'b1; a_addr = 28'h0000005; a_wdata = '0;
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL b2b_cool_ready got=%b want=0", a_ready); end
    do begin @(posedge clk); #1; n++; end while (!a_ready && n < 30);
    total++; if (n !== 10) begin bad++; $display("FAIL b2b_rd_cycle got=%0d want=10", n); end
    total++; if (a_rdata !== B2B) begin bad++; $display("FAIL b2b_rd_data got=%h want=%h", a_rdata, B2B); end
    a_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latched();
    int n;
    int lat;
    @(posedge clk); #1;
    a_wr = 1'b1; a_addr = 28'h0000020; a_wdata = D1;
    @(posedge clk); #1;
    a_addr = 28'h0000021; a_wdata = D2;
    n = 1;
    while (!a_ready && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL latch_lat got=%0d want=4", n); end
    a_wr = 1'b0;
    @(posedge clk); #1;
    op_a(1'b0, 1'b1, 28'h0000020, '0, lat);
    total++; if (a_rdata !== D1) begin bad++; $display("FAIL latch_rd20 got=%h want=%h", a_rdata, D1); end
    op_a(1'b0, 1'b1, 28'h0000021, '0, lat);
    total++; if (a_rdata !== P21) begin bad++; $display("FAIL latch_rd21 got=%h want=%h", a_rdata, P21); end
  endtask

  task automatic test_proto_err();
    int pulses;
    int lat;
    pulses = 0;
    @(posedge clk); #1;
    a_wr = 1'b1; a_rd = 1'b1; a_addr = 28'h0000030; a_wdata = E1;
    total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL perr_c0 got=%b want=0", a_perr); end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      total++;
      if (a_perr !== (k == 1)) begin
        bad++; $display("FAIL perr_c%0d got=%b want=%b", k, a_perr, (k == 1));
      end
      if (a_ready) begin
        pulses++;
        a_wr = 1'b0; a_rd = 1'b0;
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL perr_pulses got=%0d want=1", pulses); end
    total++; if (a_rdata !== P21) begin bad++; $display("FAIL perr_rdata_kept got=%h want=%h", a_rdata, P21); end
    op_a(1'b0, 1'b1, 28'h0000030, '0, lat);
    total++; if (a_rdata !== E1) begin bad++; $display("FAIL perr_rd30 got=%h want=%h", a_rdata, E1); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    pulses = 0;
    @(posedge clk); #1;
    a_wr = 1'b1; a_addr = 28'h0000009; a_wdata = NEWD;
    @(posedge clk); #1;
    a_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", a_busy); end
    total++; if (a_rdata !== 128'h0) begin bad++; $display("FAIL abort_rdata got=%h want=0", a_rdata); end
    for (int k = 0; k < 4; k++) begin
      if (a_ready) pulses++;
      @(posedge clk); #1;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_ready got=%0d want=0", pulses); end
    op_a(1'b0, 1'b1, 28'h0000009, '0, lat);
    total++; if (a_rdata !== P9) begin bad++; $display("FAIL abort_rd9 got=%h want=%h", a_rdata, P9); end
  endtask

  task automatic test_latency1();
    @(posedge clk); #1;
    b_wr = 1'b1; b_addr = 28'h0000044; b_wdata = L1;
    @(posedge clk); #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL l1_wr_ready got=%b want=1", b_ready); end
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL l1_wr_busy got=%b want=1", b_busy); end
    b_wr = 1'b0;
    @(posedge clk); #1;
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_cool_ready got=%b want=0", b_ready); end
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL l1_cool_busy got=%b want=1", b_busy); end
    @(posedge clk); #1;
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL l1_idle_busy got=%b want=0", b_busy); end
    b_rd = 1'b1; b_addr = 28'h0000144;
    @(posedge clk); #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL l1_rd_ready got=%b want=1", b_ready); end
    total++; if (b_rdata !== L1) begin bad++; $display("FAIL l1_rd_data got=%h want=%h", b_rdata, L1); end
    b_rd = 1'b0;
    @(posedge clk); #1;
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL l1_rd_single got=%b want=0", b_ready); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_preload();
    test_write_timing();
    test_read();
    test_back_to_back();
    test_latched();
    test_proto_err();
    test_reset_abort();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Memory-side responder for the 128-bit line interface driven by the cache controller: mem_read/mem_write, 28-bit line address, 128-bit data, mem_ready.
- Accepts one line request at a time and waits a programmable number of cycles.
- Completes writes into a backing line array, or returns read data, with a single-cycle mem_ready pulse.
- Serves as the slow-memory end in cache-level simulation and as a synthesizable small line store.

Parameters:
- LATENCY, 4, cycles from request acceptance to mem_ready_o pulse; legal range 1..255.
- IDX_W, 8, backing array index width; array holds 2**IDX_W lines of 128 bits.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset.
- mem_read_i  input  1  line read request, level, held by initiator until ready.
- mem_write_i  input  1  line write request, level, held by initiator until ready.
- mem_addr_i  input  28  line address; only [IDX_W-1:0] is used, upper bits are ignored (aliasing).
- mem_wdata_i  input  128  write line data.
- mem_rdata_o  output  128  read line data, registered, held until the next read completes.
- mem_ready_o  output  1  one-cycle completion pulse.
- busy_o  output  1  high in any state other than IDLE.
- proto_err_o  output  1  one-cycle pulse on an illegal request.

Interface rule: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset: rst sampled high at a rising edge forces the following.
  - State goes to IDLE; the counter clears.
  - mem_ready_o=0, busy_o=0, proto_err_o=0, mem_rdata_o=128'h0.
  - Array contents are not cleared.
  - Reset mid-transaction aborts it: no array write, no ready pulse.
- States: IDLE, WAIT, READY, COOL.
- IDLE: request = mem_read_i | mem_write_i.
  - If a request is high in cycle T, latch op, addr[IDX_W-1:0] and wdata at the end of T.
  - Then go to WAIT with cnt=LATENCY-1, or directly to READY if LATENCY==1.
- WAIT: cnt decrements every cycle; when cnt reaches 1, go to READY next. WAIT lasts exactly LATENCY-1 cycles.
- READY: lasts exactly one cycle, T+LATENCY, with mem_ready_o=1.
  - Read: mem_rdata_o already holds array[latched idx] during this cycle. It is loaded at the edge entering READY and stays stable through following cycles until the next read's READY.
  - Write: array[latched idx] <= latched wdata at the end of the READY cycle. mem_rdata_o is unchanged.
- COOL: one cycle, T+LATENCY+1; requests are ignored. The next acceptance is possible at the earliest in cycle T+LATENCY+2, giving the initiator one cycle to drop or change its request.
- Latched values are authoritative. Changes to addr/wdata or request deassertion after acceptance do not alter or cancel the transaction.
- Read and write both high in IDLE: proto_err_o pulses in cycle T+1; the transaction is treated as a write.
- A read to a line written earlier returns the written data. Write-then-read of the same line back-to-back (writeback then allocate) must be coherent.
- mem_ready_o never asserts for two consecutive cycles and never asserts without a prior acceptance.

Test Plan:
- LATENCY=4: write addr 28'h0000005 with data 128'hDEAD...BEEF in cycle 0 → mem_ready_o high only in cycle 4, busy_o high cycles 1-5, low in cycle 6.
- Then read 28'h0000005 → mem_rdata_o=128'hDEAD...BEEF during ready and held afterward. Read of never-written-after-preload 28'h0000006 returns its preload value.
- Back-to-back: initiator asserts read in the cycle after write's ready (COOL) → read accepted one cycle later, ready at accept+4, data equals the just-written line. Addresses 28'h1000005 and 28'h0000005 alias (IDX_W=8).
- Initiator changes mem_addr_i and mem_wdata_i in WAIT → array updated at the originally latched index with the originally latched data.
- mem_read_i and mem_write_i both high → proto_err_o pulse one cycle after acceptance, write performed, a single ready pulse.
- rst asserted in WAIT of a write to 28'h0000009 → no ready, busy_o=0 next cycle, mem_rdata_o=0, later read of 28'h0000009 returns old value. LATENCY=1 instance: ready in cycle T+1.
